// File: rtl/piece_collision_checker_pkg.sv
// Shared Tetris board definitions: default board geometry, scan FSM states
// and the encoding of an empty board cell.
package tetris_pkg;

  localparam int unsigned DEFAULT_BOARD_W  = 10;
  localparam int unsigned DEFAULT_BOARD_H  = 24;
  localparam int unsigned DEFAULT_COLOUR_W = 6;
  localparam int unsigned DEFAULT_ADDR_W   = 8;

  // Board RAM colour value for an unoccupied (black) cell
  localparam int unsigned COLOUR_EMPTY = 0;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    WAIT,
    FIN
  } state_t;

endpackage

// File: rtl/piece_collision_checker_board_addr_gen.sv
// board_addr_gen: maps an unsigned (x, y) board coordinate to a linear
// row-major RAM address and flags whether the coordinate lies on the board.
// Purely combinational; shared with the line-clear and render blocks.
module board_addr_gen
  import tetris_pkg::*;
#(
  parameter int unsigned BOARD_W = DEFAULT_BOARD_W,
  parameter int unsigned BOARD_H = DEFAULT_BOARD_H,
  parameter int unsigned X_W     = 8,
  parameter int unsigned Y_W     = 7,
  parameter int unsigned ADDR_W  = DEFAULT_ADDR_W
) (
  input  logic [X_W-1:0]    x,
  input  logic [Y_W-1:0]    y,
  output logic [ADDR_W-1:0] addr,
  output logic              in_bounds
);

  // Wide enough that y*BOARD_W + x cannot overflow before truncation
  localparam int unsigned W = X_W + Y_W + 4;

  logic [W-1:0] x_w;
  logic [W-1:0] y_w;
  logic [W-1:0] full;

  // Widen, linearise, truncate to the RAM address and bounds-check
  always_comb begin
    x_w       = W'(x);
    y_w       = W'(y);
    full      = y_w * W'(BOARD_W) + x_w;
    addr      = ADDR_W'(full);
    in_bounds = (x_w < W'(BOARD_W)) && (y_w < W'(BOARD_H));
  end

endmodule

// File: rtl/piece_collision_checker.sv
// piece_collision_checker: scans every cell of a candidate piece placement
// against the board RAM (one read per on-board cell, off-board cells count
// as hits) and reports one aggregate collision flag with a done pulse.
// Optional build macro PIECE_COLLISION_EARLY_EXIT_EN: stop scanning at the
// first hit instead of always visiting all CELLS cells.
module piece_collision_checker
  import tetris_pkg::*;
#(
  parameter int unsigned BOARD_W  = DEFAULT_BOARD_W,
  parameter int unsigned BOARD_H  = DEFAULT_BOARD_H,
  parameter int unsigned X_W      = 8,
  parameter int unsigned Y_W      = 7,
  parameter int unsigned COLOUR_W = DEFAULT_COLOUR_W,
  parameter int unsigned ADDR_W   = DEFAULT_ADDR_W,
  parameter int unsigned CELLS    = 4,
  parameter int unsigned RD_LAT   = 1
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [CELLS*X_W-1:0] cell_x,
  input  logic [CELLS*Y_W-1:0] cell_y,
  output logic                 ready,
  output logic                 done,
  output logic                 collision,
  output logic [ADDR_W-1:0]    ram_addr,
  output logic                 ram_rd,
  input  logic [COLOUR_W-1:0]  ram_q
);

  localparam int unsigned IDX_W = (CELLS  > 1) ? $clog2(CELLS)  : 1;
  localparam int unsigned LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_t               state;
  state_t               state_n;
  logic [CELLS*X_W-1:0] cx_q;
  logic [CELLS*Y_W-1:0] cy_q;
  logic [IDX_W-1:0]     idx;
  logic [IDX_W-1:0]     idx_n;
  logic [LAT_W-1:0]     lat_cnt;
  logic [LAT_W-1:0]     lat_cnt_n;
  logic                 hit;
  logic                 hit_n;
  logic                 advance;
  logic                 last_cell;

  logic [X_W-1:0]       cur_x;
  logic [Y_W-1:0]       cur_y;
  logic [ADDR_W-1:0]    cur_addr;
  logic                 cur_in;

  // Select the coordinates of the cell currently being examined
  always_comb begin
    cur_x = cx_q[idx*X_W +: X_W];
    cur_y = cy_q[idx*Y_W +: Y_W];
  end

  board_addr_gen #(
    .BOARD_W (BOARD_W),
    .BOARD_H (BOARD_H),
    .X_W     (X_W),
    .Y_W     (Y_W),
    .ADDR_W  (ADDR_W)
  ) u_addr_gen (
    .x         (cur_x),
    .y         (cur_y),
    .addr      (cur_addr),
    .in_bounds (cur_in)
  );

  // State register
  always_ff @(posedge clock) begin
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  end

  // Next-state, scan bookkeeping and hit accumulation
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    lat_cnt_n = lat_cnt;
    hit_n     = hit;
    advance   = 1'b0;
    last_cell = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = CHECK;
          idx_n   = '0;
          hit_n   = 1'b0;
        end
      end
      CHECK: begin
        if (cur_in) begin
          state_n   = WAIT;
          lat_cnt_n = '0;
        end else begin
          hit_n   = 1'b1;
          advance = 1'b1;
        end
      end
      WAIT: begin
        if (lat_cnt == LAT_W'(RD_LAT - 1)) begin
          hit_n   = hit | (ram_q != COLOUR_W'(COLOUR_EMPTY));
          advance = 1'b1;
        end else begin
          lat_cnt_n = lat_cnt + 1'b1;
        end
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (advance) begin
`ifdef PIECE_COLLISION_EARLY_EXIT_EN
      last_cell = (idx == IDX_W'(CELLS - 1)) || hit_n;
`else
      last_cell = (idx == IDX_W'(CELLS - 1));
`endif
      if (last_cell) begin
        state_n = FIN;
      end else begin
        idx_n   = idx + 1'b1;
        state_n = CHECK;
      end
    end
  end

  // Datapath registers; collision is loaded on entry to FIN so it is
  // already valid in the cycle done is asserted
  always_ff @(posedge clock) begin
    if (!resetn) begin
      idx       <= '0;
      lat_cnt   <= '0;
      hit       <= 1'b0;
      collision <= 1'b0;
      cx_q      <= '0;
      cy_q      <= '0;
    end else begin
      idx     <= idx_n;
      lat_cnt <= lat_cnt_n;
      hit     <= hit_n;
      if (state == IDLE && start) begin
        cx_q      <= cell_x;
        cy_q      <= cell_y;
        collision <= 1'b0;
      end
      if (state != FIN && state_n == FIN) collision <= hit_n;
    end
  end

  // Moore outputs; the address stays on the bus for the whole read
  always_comb begin
    ready    = (state == IDLE);
    done     = (state == FIN);
    ram_rd   = (state == CHECK) && cur_in;
    ram_addr = (state == CHECK || state == WAIT) ? cur_addr : '0;
  end

endmodule
